speed_pi_regulator: RTL

- Closed-loop speed regulator upstream of the motor control top; produces the PWM duty command (i_pwm_command) from the measured speed and a target speed.
- Runs one PI update per valid speed sample from the speed meter.
- Uses a sequential shift-add multiplier, one coefficient bit per cycle, so no hard multipliers are needed.
- Integrator has anti-windup clamping; output saturates to [0, pwm_max].

---
 rtl/speed_pi_regulator.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/speed_pi_regulator.sv
// rtl/speed_pi_regulator.sv - PI speed regulator producing a saturated PWM duty command
// One PI update per accepted speed sample; products are formed by a serial shift-add multiplier.
module speed_pi_regulator #(
    parameter int K_SPDWIDTH = 15,
    parameter int K_PWMRES   = 10,
    parameter int K_COEFW    = 8,
    parameter int K_FRAC     = 4,
    parameter int K_ACCW     = 28
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [K_SPDWIDTH-1:0] i_target_speed,
    input  logic [K_SPDWIDTH-1:0] i_speed,
    input  logic                  i_speed_valid,
    input  logic [K_COEFW-1:0]    i_kp,
    input  logic [K_COEFW-1:0]    i_ki,
    input  logic                  i_integ_clear,
    input  logic [K_PWMRES-1:0]   i_pwm_max,
    output logic [K_PWMRES-1:0]   o_pwm_cmd,
    output logic                  o_cmd_valid,
    output logic                  o_busy
);

    localparam int CNTW = (K_COEFW > 1) ? $clog2(K_COEFW) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(K_COEFW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MUL_P,
        S_MUL_I,
        S_ACC,
        S_OUT
    } state_t;

    state_t state, state_nx;

    logic [K_SPDWIDTH-1:0]    target_r;
    logic [K_SPDWIDTH-1:0]    speed_r;
    logic [K_COEFW-1:0]       kp_r;
    logic [K_COEFW-1:0]       ki_r;
    logic [K_COEFW-1:0]       coef_sr;
    logic [CNTW-1:0]          cnt;
    logic signed [K_ACCW-1:0] mcand;
    logic signed [K_ACCW-1:0] p_acc;
    logic signed [K_ACCW-1:0] q_acc;
    logic signed [K_ACCW-1:0] integ;

    logic                     accept;
    logic                     mul_last;
    logic signed [K_ACCW-1:0] err_ext;
    logic signed [K_ACCW-1:0] pwm_max_ext;
    logic signed [K_ACCW-1:0] integ_lim;
    logic signed [K_ACCW-1:0] integ_sum;
    logic signed [K_ACCW-1:0] integ_clamped;
    logic signed [K_ACCW-1:0] out_sum;
    logic signed [K_ACCW-1:0] out_y;
    logic [K_PWMRES-1:0]      pwm_sat;

    assign accept   = (state == S_IDLE) && i_enable && i_speed_valid;
    assign mul_last = (cnt == CNT_LAST);
    assign o_busy   = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (i_speed_valid) state_nx = S_ERR;
            S_ERR:   state_nx = S_MUL_P;
            S_MUL_P: if (mul_last) state_nx = S_MUL_I;
            S_MUL_I: if (mul_last) state_nx = S_ACC;
            S_ACC:   state_nx = S_OUT;
            S_OUT:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (!i_enable) state_nx = S_IDLE;
    end

    // Widening both operands past K_SPDWIDTH+1 bits gives the sign-extended error directly.
    always_comb begin
        err_ext     = $signed({{(K_ACCW-K_SPDWIDTH){1'b0}}, target_r})
                    - $signed({{(K_ACCW-K_SPDWIDTH){1'b0}}, speed_r});
        pwm_max_ext = $signed({{(K_ACCW-K_PWMRES){1'b0}}, i_pwm_max});
        integ_lim   = pwm_max_ext <<< K_FRAC;
        integ_sum   = integ + q_acc;
        if (integ_sum[K_ACCW-1]) begin
            integ_clamped = '0;
        end else if (integ_sum > integ_lim) begin
            integ_clamped = integ_lim;
        end else begin
            integ_clamped = integ_sum;
        end
        out_sum = p_acc + integ;
        out_y   = out_sum >>> K_FRAC;
        if (out_y[K_ACCW-1]) begin
            pwm_sat = '0;
        end else if (out_y > pwm_max_ext) begin
            pwm_sat = i_pwm_max;
        end else begin
            pwm_sat = out_y[K_PWMRES-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            target_r    <= '0;
            speed_r     <= '0;
            kp_r        <= '0;
            ki_r        <= '0;
            coef_sr     <= '0;
            cnt         <= '0;
            mcand       <= '0;
            p_acc       <= '0;
            q_acc       <= '0;
            integ       <= '0;
            o_pwm_cmd   <= '0;
            o_cmd_valid <= 1'b0;
        end else if (!i_enable) begin
            integ       <= '0;
            o_pwm_cmd   <= '0;
            o_cmd_valid <= 1'b0;
        end else begin
            o_cmd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        target_r <= i_target_speed;
                        speed_r  <= i_speed;
                        kp_r     <= i_kp;
                        ki_r     <= i_ki;
                    end
                end
                S_ERR: begin
                    mcand   <= err_ext;
                    coef_sr <= kp_r;
                    p_acc   <= '0;
                    q_acc   <= '0;
                    cnt     <= '0;
                end
                S_MUL_P: begin
                    if (coef_sr[0]) p_acc <= p_acc + mcand;
                    if (mul_last) begin
                        mcand   <= err_ext;
                        coef_sr <= ki_r;
                        cnt     <= '0;
                    end else begin
                        mcand   <= mcand <<< 1;
                        coef_sr <= coef_sr >> 1;
                        cnt     <= cnt + CNTW'(1);
                    end
                end
                S_MUL_I: begin
                    if (coef_sr[0]) q_acc <= q_acc + mcand;
                    mcand   <= mcand <<< 1;
                    coef_sr <= coef_sr >> 1;
                    cnt     <= cnt + CNTW'(1);
                end
                S_ACC: begin
                    integ <= integ_clamped;
                end
                S_OUT: begin
                    o_pwm_cmd   <= pwm_sat;
                    o_cmd_valid <= 1'b1;
                end
                default: ;
            endcase
            // Clearing has priority, so a clear during ACC leaves OUT using a zero integrator.
            if (i_integ_clear) integ <= '0;
        end
    end

endmodule
